load_store_unit: RTL

- Memory-access stage directly downstream of the single-cycle datapath.
- Consumes the ALU result as the effective address and register operand 2 as store data, runs a handshaked transaction on a word-wide data-memory bus, and returns an aligned, extended load result for the register write-back mux.
- Raises stall while a transaction is in flight so PC and register-file writes hold.
- Adds RV32 byte/halfword semantics: LB/LH/LW/LBU/LHU/SB/SH/SW.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/load_store_unit_if.sv | 29 ++
 rtl/lsu_align.sv | 53 +++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// access-size decoding and the alignment rule.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // Undefined encodings (011, 110, 111) fall through to a full-word access.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      default:     f3_size = SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3_size(f3))
      SZ_H:    is_misaligned = off[0];
      SZ_W:    is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Handshake: the master holds mem_req and its payload stable until the cycle
  // in which mem_gnt=1, which completes the request. For a read, exactly one
  // later cycle carries mem_rvalid=1 with mem_rdata; there is no back-pressure
  // on the read response.
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store byte enables/replication and load
// lane extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_result
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Halfword lanes use only off[1], which also gives forced natural alignment.
  always_comb begin
    st_be        = BE_W;
    st_wdata_rep = st_wdata;
    case (f3_size(st_funct3))
      SZ_B: begin
        st_be        = 4'b0001 << st_off;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_be        = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half   = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    ld_result = ld_word;
    case (f3_size(ld_funct3))
      SZ_B: ld_result = ld_funct3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H: ld_result = ld_funct3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: latches a load/store, runs it on the memory bus and returns
// the extended load result. Optional LSU_MISALIGN_TRAP_EN adds a misalign trap output.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  load_store_unit_if.master     mem,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                  misalign,
`endif
  output lsu_state_t            state_dbg
);

  lsu_state_t            state;
  logic [2:0]            lat_f3;
  logic [1:0]            lat_off;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [3:0]            mem_be_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [3:0]            be_c;
  logic [DATA_WIDTH-1:0] wrep_c;
  logic [DATA_WIDTH-1:0] ld_res_c;

  lsu_align u_align (
    .st_funct3    (req_funct3),
    .st_off       (req_addr[1:0]),
    .st_wdata     (req_wdata),
    .st_be        (be_c),
    .st_wdata_rep (wrep_c),
    .ld_funct3    (lat_f3),
    .ld_off       (lat_off),
    .ld_word      (mem.mem_rdata),
    .ld_result    (ld_res_c)
  );

  assign stall         = (state == REQ) || (state == WAIT) || ((state == IDLE) && req_valid);
  assign state_dbg     = state;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      rdata       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      lat_f3      <= '0;
      lat_off     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Bus payload is computed once here; the request inputs are not looked at again.
            mem_we_q    <= req_we;
            mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_q    <= be_c;
            mem_wdata_q <= wrep_c;
            lat_f3      <= req_funct3;
            lat_off     <= req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
            if (is_misaligned(req_funct3, req_addr[1:0])) begin
              state    <= DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
              rdata    <= '0;
            end else begin
              state     <= REQ;
              mem_req_q <= 1'b1;
            end
`else
            state     <= REQ;
            mem_req_q <= 1'b1;
`endif
          end
        end
        REQ: begin
          if (mem.mem_gnt) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              state <= DONE;
              done  <= 1'b1;
              rdata <= '0;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            rdata <= ld_res_c;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
